// File: rtl/lowpass.sv
// 2nd-order Butterworth low-pass biquad (Direct Form I), one sample per clk,
// selectable cutoff; define LOWPASS_SAT_EN to saturate instead of wrap.
module lowpass (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  filter,
  input  logic [15:0] highpassIn,
  output logic [15:0] highpassOut
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 40;

  logic signed [DW-1:0] x1, x2, y1, y2;
  logic        [1:0]    prev_filter;
  logic signed [DW-1:0] b0, b1, b2, a1, a2;
  logic signed [DW-1:0] x0, x1_e, x2_e, y1_e, y2_e;
  logic signed [PW-1:0] p0, p1, p2, p3, p4;
  logic signed [AW-1:0] acc, rnd;
  logic signed [DW-1:0] res;
  logic                 chg;

  // Q2.14 coefficient table
  always_comb begin
    b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    case (filter)
      2'd1: begin
        b0 = 16'sd64;   b1 = 16'sd128;  b2 = 16'sd64;   a1 = -16'sd29743; a2 = 16'sd13615;
      end
      2'd2: begin
        b0 = 16'sd811;  b1 = 16'sd1622; b2 = 16'sd811;  a1 = -16'sd20965; a2 = 16'sd7825;
      end
      2'd3: begin
        b0 = 16'sd4799; b1 = 16'sd9598; b2 = 16'sd4799; a1 = 16'sd0;      a2 = 16'sd2811;
      end
      default: ;
    endcase
  end

  // A filter change restarts from zero history on the same edge
  assign chg  = (filter != prev_filter);
  assign x0   = $signed(highpassIn);
  assign x1_e = chg ? '0 : x1;
  assign x2_e = chg ? '0 : x2;
  assign y1_e = chg ? '0 : y1;
  assign y2_e = chg ? '0 : y2;

  assign p0 = b0 * x0;
  assign p1 = b1 * x1_e;
  assign p2 = b2 * x2_e;
  assign p3 = a1 * y1_e;
  assign p4 = a2 * y2_e;

  assign acc = AW'(p0) + AW'(p1) + AW'(p2) - AW'(p3) - AW'(p4);
  assign rnd = (acc + 40'sd8192) >>> 14;

`ifdef LOWPASS_SAT_EN
  always_comb begin
    res = DW'(rnd);
    if (rnd > 40'sd32767)       res = 16'sd32767;
    else if (rnd < -40'sd32768) res = -16'sd32768;
  end
`else
  assign res = DW'(rnd);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      highpassOut <= '0;
      prev_filter <= '0;
      x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
    end else begin
      prev_filter <= filter;
      if (filter == 2'd0) begin
        highpassOut <= highpassIn;
        x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      end else if (chg) begin
        highpassOut <= res;
        x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      end else begin
        highpassOut <= res;
        x1 <= x0;
        x2 <= x1;
        y1 <= res;
        y2 <= y1;
      end
    end
  end

endmodule

// File: tb/tb_lowpass.sv
// Self-checking bench for lowpass: arithmetic reference model plus directed vectors.
module tb_lowpass;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  filter = 2'd0;
  logic [15:0] highpassIn = 16'd0;
  logic [15:0] highpassOut;

  int checks = 0;
  int errors = 0;

  lowpass dut (
    .clk(clk),
    .reset(reset),
    .filter(filter),
    .highpassIn(highpassIn),
    .highpassOut(highpassOut)
  );

  always #5 clk = ~clk;

  // Reference model: history kept as plain integers, coefficients as a table
  int coef [4][5] = '{'{0, 0, 0, 0, 0},
                      '{64, 128, 64, -29743, 13615},
                      '{811, 1622, 811, -20965, 7825},
                      '{4799, 9598, 4799, 0, 2811}};
  int hx [2];
  int hy [2];
  int mprev = 0;
  int exp_y = 0;

  function automatic int limit16(longint v);
`ifdef LOWPASS_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    return int'(shortint'(v));
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hx[0] <= 0; hx[1] <= 0; hy[0] <= 0; hy[1] <= 0;
      mprev <= 0; exp_y <= 0;
    end else begin
      int f, x, y, h0, h1, g0, g1;
      longint acc;
      f = int'(filter);
      x = int'($signed(highpassIn));
      mprev <= f;
      if (f == 0) begin
        exp_y <= x;
        hx[0] <= 0; hx[1] <= 0; hy[0] <= 0; hy[1] <= 0;
      end else begin
        h0 = (f == mprev) ? hx[0] : 0;
        h1 = (f == mprev) ? hx[1] : 0;
        g0 = (f == mprev) ? hy[0] : 0;
        g1 = (f == mprev) ? hy[1] : 0;
        acc = longint'(coef[f][0]) * x + longint'(coef[f][1]) * h0 + longint'(coef[f][2]) * h1
            - longint'(coef[f][3]) * g0 - longint'(coef[f][4]) * g1;
        y = limit16((acc + 64'sd8192) >>> 14);
        exp_y <= y;
        if (f == mprev) begin
          hx[0] <= x; hx[1] <= h0; hy[0] <= y; hy[1] <= g0;
        end else begin
          hx[0] <= 0; hx[1] <= 0; hy[0] <= 0; hy[1] <= 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (int'($signed(highpassOut)) != exp_y) begin
      errors++;
      $display("FAIL model_cmp t=%0t actual=%0d required=%0d", $time,
               $signed(highpassOut), exp_y);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=[%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic drive(input int f, input int x);
    @(negedge clk);
    filter = 2'(f);
    highpassIn = 16'(x);
  endtask

  function automatic int out_now();
    return int'($signed(highpassOut));
  endfunction

  function automatic int sine(input int n);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 48.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  initial begin
    int mn, mx;
    bit neg_seen;
    #1;
    chk("reset_out", out_now(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Bypass
    drive(0, 100);    @(posedge clk); #1; chk("bypass_100", out_now(), 100);
    drive(0, -200);   @(posedge clk); #1; chk("bypass_m200", out_now(), -200);
    drive(0, 32767);  @(posedge clk); #1; chk("bypass_max", out_now(), 32767);

    // Asynchronous reset mid-cycle while output is nonzero
    #2 reset = 1'b1;
    #1 chk("async_reset", out_now(), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0);      @(posedge clk); #1; chk("post_reset", out_now(), 0);

    // Impulse at 1 kHz
    repeat (3) drive(1, 0);
    drive(1, 16384);  @(posedge clk); #1; chk("imp1k_0", out_now(), 64);
    drive(1, 0);      @(posedge clk); #1; chk("imp1k_1", out_now(), 244);
    repeat (20) drive(1, 0);

    // Impulse at 12 kHz
    repeat (3) drive(3, 0);
    drive(3, 16384);  @(posedge clk); #1; chk("imp12k_0", out_now(), 4799);
    repeat (20) drive(3, 0);

    // DC gain at 4 kHz
    repeat (200) drive(2, 10000);
    @(posedge clk); #1;
    chk_range("dc_settle", out_now(), 9998, 10002);

    // Step overshoot at 12 kHz
    repeat (5) drive(3, 0);
    mn = 0; mx = 0; neg_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(3, 32767);
      @(posedge clk); #1;
      if (i == 0) chk("step_first", out_now(), 9598);
      if (i == 1) chk("step_second", out_now(), 28793);
      if (out_now() < mn) mn = out_now();
      if (out_now() > mx) mx = out_now();
      if (out_now() < 0) neg_seen = 1'b1;
    end
`ifdef LOWPASS_SAT_EN
    chk_range("step_sat_min", mn, 0, 32767);
    chk("step_sat_peak", mx, 32767);
`else
    chk("step_wrap_neg", int'(neg_seen), 1);
`endif

    // Sine at 12 kHz, then switch to 1 kHz on the sample at the sine peak
    for (int n = 0; n < 60; n++) drive(3, sine(n));
    drive(1, sine(60)); @(posedge clk); #1; chk("switch_edge", out_now(), 128);
    for (int n = 61; n < 110; n++) begin
      drive(1, sine(n));
      @(posedge clk); #1;
      chk_range("switch_fs", out_now(), -32768, 32767);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lowpass.md
LOWPASS -- requirements
Module: lowpass

Interface
REQ-001 The block SHALL have the port clk, an input of 1 bit, which is the sample clock; one audio sample is processed per rising edge (fs = 48 kHz nominal).
REQ-002 The block SHALL have the port reset, an input of 1 bit, which is an asynchronous, active-high reset.
REQ-003 The block SHALL have the port filter, an input of 2 bits, which selects the response: 0 = bypass, 1 = 1 kHz, 2 = 4 kHz, 3 = 12 kHz cutoff.
REQ-004 The block SHALL have the port highpassIn, an input of 16 bits, which is a signed two's-complement audio input sample.
REQ-005 The block SHALL have the port highpassOut, an output of 16 bits, which is the signed filtered output sample, registered.

Function
REQ-006 The block SHALL implement a 2nd-order Butterworth low-pass biquad in Direct Form I: y = (b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> 14.
REQ-007 Coefficients SHALL be signed 16-bit Q2.14 constants in the order b0, b1, b2, a1, a2.
REQ-008 For filter=1 (1 kHz), the coefficients SHALL be 64, 128, 64, −29743, 13615.
REQ-009 For filter=2 (4 kHz), the coefficients SHALL be 811, 1622, 811, −20965, 7825.
REQ-010 For filter=3 (12 kHz), the coefficients SHALL be 4799, 9598, 4799, 0, 2811.
REQ-011 Products SHALL be full 32-bit signed, summed in a signed 40-bit accumulator.
REQ-012 The accumulator SHALL have 2^13 added to it before an arithmetic right shift by 14 (round-half-up).
REQ-013 Latency SHALL be one clock: highpassOut after edge n equals y computed from highpassIn sampled at edge n.
REQ-014 History SHALL be updated every clock: x2←x1, x1←x0, y2←y1, y1←highpassOut (the post-saturation/truncation value).
REQ-015 With filter=0, highpassOut SHALL equal highpassIn registered (one-clock latency), and all history registers SHALL be held at zero.
REQ-016 Any change of filter between consecutive clock edges SHALL zero x1, x2, y1 and y2 on that edge.
REQ-017 The output on the edge of a filter change SHALL be computed with the new coefficients and zero history.
REQ-018 No input handshake SHALL be used; highpassIn is sampled unconditionally on every rising clk edge.

Reset
REQ-019 While reset=1, highpassOut, x1, x2, y1, y2 and the stored previous filter value SHALL be 0 immediately, without waiting for clk.
REQ-020 Assertion of reset in mid-stream SHALL discard all history.
REQ-021 On the first edge after release of reset, processing SHALL start with zero history.

Configuration
REQ-022 With the macro LOWPASS_SAT_EN defined, the rounded result SHALL be saturated to [−32768, 32767] before being driven to highpassOut and fed back to y1.
REQ-023 With LOWPASS_SAT_EN undefined, the rounded result SHALL be truncated to its low 16 bits (two's-complement wrap).

Verification
REQ-024 Reset test: drive reset=1 asynchronously mid-cycle with nonzero output; highpassOut SHALL be 0 immediately, and the first output after release with input 0 SHALL be 0.
REQ-025 Bypass test: filter=0, input sequence 100, −200, 32767; highpassOut SHALL be 100, −200, 32767 on the edges following each sample.
REQ-026 Impulse test: filter=1, one sample of 16384 then zeros; highpassOut SHALL be 64 on the first edge, then 244 on the next edge.
REQ-027 Impulse test: filter=3, one sample of 16384; first output SHALL be 4799.
REQ-028 DC test: filter=2, constant input 10000 for 200 clocks; highpassOut SHALL settle to 10000 ±2.
REQ-029 Overflow test: filter=3, step 0→32767; with LOWPASS_SAT_EN the output SHALL never exceed 32767 or go negative; without it, an overshoot sample SHALL wrap negative.
REQ-030 Filter switch test: 1 kHz sine (amplitude 32767) at filter=3, switch to filter=1; the history SHALL be zeroed, and the output SHALL restart from 0-state without spikes beyond full scale.
